// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions.
// Purpose: opcode constants and immediate-format types used by the decode stage.
// Contents:
//   OP_*          opcode field values, each at the width of its own format's opcode field
//   imm_fmt_t     immediate format selected by the opcode decoder
//   decode_fmt()  priority opcode decoder, instruction word -> imm_fmt_t
package legv8_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned DataWidth  = 64;

  // D-type opcodes, a[31:21]
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  // CB-type opcodes, a[31:24]
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  // B-type opcode, a[31:26]
  localparam logic [5:0]  OP_B    = 6'b000101;
  // I-type opcodes, a[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b10_0100_0100;
  localparam logic [9:0]  OP_SUBI = 10'b11_0100_0100;

  typedef enum logic [2:0] {
    FMT_D,
    FMT_CB,
    FMT_B,
    FMT_I,
    FMT_NONE
  } imm_fmt_t;

  // Top-down priority: the first matching format wins.
  function automatic imm_fmt_t decode_fmt(input logic [InstrWidth-1:0] instr);
    imm_fmt_t fmt;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      fmt = FMT_D;
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
      fmt = FMT_CB;
    end else if (instr[31:26] == OP_B) begin
      fmt = FMT_B;
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      fmt = FMT_I;
    end else begin
      fmt = FMT_NONE;
    end
    return fmt;
  endfunction

endpackage

// File: rtl/sign_ext_core.sv
// Combinational immediate extractor.
// Purpose: decodes the instruction format and extends that format's immediate to 64 bits.
// Ports:
//   a    in   32  instruction word
//   fmt  out  3   decoded immediate format
//   ext  out  64  extended immediate (zero for unrecognised opcodes)
module sign_ext_core
  import legv8_pkg::*;
(
  input  logic [InstrWidth-1:0] a,
  output imm_fmt_t              fmt,
  output logic [DataWidth-1:0]  ext
);

  always_comb begin
    fmt = decode_fmt(a);
    ext = '0;
    // Each sign bit is the MSB of its own field; no other instruction bits reach the upper word.
    unique case (fmt)
      FMT_D:    ext = {{55{a[20]}}, a[20:12]};
      FMT_CB:   ext = {{45{a[23]}}, a[23:5]};
      FMT_B:    ext = {{38{a[25]}}, a[25:0]};
      FMT_I:    ext = {52'h0, a[21:10]};
      default:  ext = '0;
    endcase
  end

endmodule

// File: rtl/sign_ext.sv
// LEGv8 immediate sign/zero-extension unit, registered output.
// Purpose: extends the current instruction's immediate and holds it for the ALU and
//          branch-target adder. One cycle of latency, no enable.
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-low reset (0 clears y)
//   a      in   32  instruction word
//   y      out  64  extended immediate, registered
module sign_ext
  import legv8_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [InstrWidth-1:0] a,
  output logic [DataWidth-1:0]  y
);

  imm_fmt_t             fmt;
  logic [DataWidth-1:0] ext;
  logic [DataWidth-1:0] y_d;

  sign_ext_core u_core (
    .a   (a),
    .fmt (fmt),
    .ext (ext)
  );

  // Unrecognised opcodes always load zero, whatever the extractor produced.
  always_comb begin
    y_d = (fmt == FMT_NONE) ? '0 : ext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y <= '0;
    end else begin
      y <= y_d;
    end
  end

endmodule

// File: tb/tb_sign_ext.sv
// Self-checking bench for sign_ext: a driver pushes expected values into a scoreboard queue
// at the falling edge; a monitor pops and compares one value after every rising edge.
module tb_sign_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [63:0] y;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  sign_ext dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .y     (y)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: field values from arithmetic on the word, signed fields folded by range.
  function automatic logic [63:0] model(input logic [31:0] w);
    int unsigned u;
    longint      v;
    u = w;
    if ((u >> 21) == 32'h7C2 || (u >> 21) == 32'h7C0) begin
      v = longint'((u >> 12) % 512);
      if (v >= 256) v = v - 512;
      return v;
    end
    if ((u >> 24) == 32'hB4 || (u >> 24) == 32'hB5) begin
      v = longint'((u >> 5) % (1 << 19));
      if (v >= (1 << 18)) v = v - (1 << 19);
      return v;
    end
    if ((u >> 26) == 32'd5) begin
      v = longint'(u % (1 << 26));
      if (v >= (1 << 25)) v = v - (1 << 26);
      return v;
    end
    if ((u >> 22) == 32'h244 || (u >> 22) == 32'h344) begin
      v = longint'((u >> 10) % 4096);
      return v;
    end
    return 64'h0;
  endfunction

  // Monitor: every rising edge with an outstanding expectation produces one comparison.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("scoreboard", y, exp_q.pop_front());
    end
  end

  task automatic drive(input logic [31:0] w, input logic [63:0] req);
    @(negedge clk);
    a = w;
    exp_q.push_back(req);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w[31:21] = 11'h7C2;
      1: w[31:21] = 11'h7C0;
      2: w[31:24] = 8'hB4;
      3: w[31:24] = 8'hB5;
      4: w[31:26] = 6'b000101;
      5: w[31:22] = 10'h244;
      6: w[31:22] = 10'h344;
      default: ;
    endcase
    return w;
  endfunction

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'h0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    a     = 32'h0;
    #1 reset = 1'b0;

    // Reset asserted with a decodable word applied mid-cycle.
    #11 a = 32'hF85FF400;
    #1 check("reset_immediate", y, 64'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", y, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);

    drive(32'hF85FF400, 64'hFFFF_FFFF_FFFF_FFFF);  // LDUR imm9=0x1FF
    drive(32'hF8400400, 64'h0);                    // LDUR imm9=0
    drive(32'hF81FE400, 64'hFFFF_FFFF_FFFF_FFFE);  // STUR imm9=0x1FE
    drive(32'hF8000400, 64'h0);                    // STUR imm9=0
    drive(32'hB4000300, 64'h18);                   // CBZ imm19=24
    drive(32'hB4FFFFE0, 64'hFFFF_FFFF_FFFF_FFFF);  // CBZ imm19=-1
    drive(32'hB5800000, 64'hFFFF_FFFF_FFFC_0000);  // CBNZ most negative
    drive(32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF);  // B imm26=-1
    drive(32'h15FFFFFF, 64'h0000_0000_01FF_FFFF);  // B most positive
    drive(32'h913FFC00, 64'hFFF);                  // ADDI imm12=0xFFF
    drive(32'hD1000400, 64'h1);                    // SUBI imm12=1
    drive(32'h8B000000, 64'h0);                    // ADD: not an immediate format
    drive(32'hF84FFFFF, 64'h0000_0000_0000_00FF);  // LDUR: op2/Rn/Rt bits do not leak

    // Two changes between edges: only the value present at the edge counts.
    @(negedge clk);
    a = 32'hF85FF400;
    #2 a = 32'h8B000000;
    #1 a = 32'hB4000300;
    exp_q.push_back(64'h18);

    repeat (300) begin
      w = rand_word();
      drive(w, model(w));
    end

    // Load a nonzero value, then assert reset mid-cycle.
    drive(32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("reset_midcycle", y, 64'h0);
    @(posedge clk);
    #1 check("reset_midcycle_hold", y, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(32'hB4000300, 64'h18);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
